// File: rtl/vga_pkg.sv
// Shared VGA screen geometry and the encodings used by the block motion path.
package vga_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Direction code carried from the arbiter into the motion FSM.
  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_C    = 3'd1,
    DIR_U    = 3'd2,
    DIR_D    = 3'd3,
    DIR_L    = 3'd4,
    DIR_R    = 3'd5
  } dir_t;

  // Motion FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_HOLD = 2'd2
  } motion_state_t;

endpackage

// File: rtl/block_motion_ctrl_debouncer.sv
// Two-flop synchronizer followed by a level debouncer for one raw push-button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_25MHz,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] count;

  // Bring the asynchronous button into the pixel clock domain.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Accept the new level only after it has disagreed with the current one for a full window.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      level <= 1'b0;
    end else if (sync_b == level) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
      level <= sync_b;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/block_motion_ctrl.sv
// Owns the moving block position: debounced buttons, fixed-priority arbiter,
// auto-repeat motion FSM and commits aligned to the start of vertical blanking.
module block_motion_ctrl
  import vga_pkg::*;
#(
  parameter int STEP            = 32,
  parameter int SCREEN_W        = vga_pkg::SCREEN_W,
  parameter int SCREEN_H        = vga_pkg::SCREEN_H,
  parameter int X_INIT          = 320,
  parameter int Y_INIT          = 0,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic        clk_25MHz,
  input  logic        reset_n,
  input  logic        btnC,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnL,
  input  logic        btnR,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic [10:0] block_x,
  output logic [10:0] block_y,
  output logic        move_pulse,
  output logic        busy
);

  localparam logic [10:0] STEP_V   = 11'(STEP);
  localparam logic [10:0] W_V      = 11'(SCREEN_W);
  localparam logic [10:0] H_V      = 11'(SCREEN_H);
  localparam logic [10:0] X_INIT_V = 11'(X_INIT);
  localparam logic [10:0] Y_INIT_V = 11'(Y_INIT);
  localparam logic [23:0] REP_LAST = 24'(REPEAT_CYCLES - 1);
  localparam logic [23:0] REP_MAX  = 24'hFF_FFFF;

  logic db_c, db_u, db_d, db_l, db_r;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
    .clk_25MHz(clk_25MHz), .reset_n(reset_n), .raw(btnC), .level(db_c));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_u (
    .clk_25MHz(clk_25MHz), .reset_n(reset_n), .raw(btnU), .level(db_u));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (
    .clk_25MHz(clk_25MHz), .reset_n(reset_n), .raw(btnD), .level(db_d));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
    .clk_25MHz(clk_25MHz), .reset_n(reset_n), .raw(btnL), .level(db_l));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
    .clk_25MHz(clk_25MHz), .reset_n(reset_n), .raw(btnR), .level(db_r));

  dir_t          winner;
  dir_t          dir;
  dir_t          next_dir;
  motion_state_t state;
  motion_state_t next_state;
  logic          commit_point;
  logic          commit;
  logic [23:0]   rep_cnt;
  logic [10:0]   step_x;
  logic [10:0]   step_y;

  // Only one pixel per frame matches, so this also limits commits to one per frame.
  assign commit_point = (hcount == 11'd0) && (vcount == H_V);
  assign busy         = (state == ST_PEND);

  // Fixed priority C > U > D > L > R among the debounced levels.
  always_comb begin
    winner = DIR_NONE;
    if (db_c)      winner = DIR_C;
    else if (db_u) winner = DIR_U;
    else if (db_d) winner = DIR_D;
    else if (db_l) winner = DIR_L;
    else if (db_r) winner = DIR_R;
  end

  // Next-state logic: requests wait in PEND for the blanking commit point, HOLD handles auto-repeat.
  always_comb begin
    next_state = state;
    next_dir   = dir;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (winner != DIR_NONE) begin
          next_state = ST_PEND;
          next_dir   = winner;
        end
      end
      ST_PEND: begin
        if (winner == DIR_NONE) begin
          next_state = ST_IDLE;
        end else if (commit_point) begin
          commit     = 1'b1;
          next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (winner == DIR_NONE) begin
          next_state = ST_IDLE;
        end else if (winner != dir) begin
          next_dir   = winner;
          next_state = ST_PEND;
        end else if (rep_cnt >= REP_LAST) begin
          next_state = ST_PEND;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State and latched direction registers.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      dir   <= DIR_NONE;
    end else begin
      state <= next_state;
      dir   <= next_dir;
    end
  end

  // Auto-repeat timer: restarts on each commit and saturates rather than wrapping.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt <= '0;
    end else if (commit) begin
      rep_cnt <= '0;
    end else if (state == ST_HOLD && rep_cnt != REP_MAX) begin
      rep_cnt <= rep_cnt + 24'd1;
    end
  end

  // Candidate position for the latched direction, wrapping around the screen edges.
  always_comb begin
    step_x = block_x;
    step_y = block_y;
    case (dir)
      DIR_C: begin
        step_x = X_INIT_V;
        step_y = Y_INIT_V;
      end
      DIR_U: step_y = (block_y < STEP_V) ? (H_V - STEP_V) : (block_y - STEP_V);
      DIR_D: step_y = ((block_y + STEP_V) >= H_V) ? 11'd0 : (block_y + STEP_V);
      DIR_L: step_x = (block_x < STEP_V) ? (W_V - STEP_V) : (block_x - STEP_V);
      DIR_R: step_x = ((block_x + STEP_V) >= W_V) ? 11'd0 : (block_x + STEP_V);
      default: begin
        step_x = block_x;
        step_y = block_y;
      end
    endcase
  end

  // Position only changes together with the commit strobe so the draw path never sees a torn block.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      block_x    <= X_INIT_V;
      block_y    <= Y_INIT_V;
      move_pulse <= 1'b0;
    end else begin
      move_pulse <= commit;
      if (commit) begin
        block_x <= step_x;
        block_y <= step_y;
      end
    end
  end

endmodule

// File: tb/tb_block_motion_ctrl.sv
// Self-checking bench for block_motion_ctrl with a compressed VGA counter model
// and a scoreboard of expected committed positions.
module tb_block_motion_ctrl;

  localparam int STEP     = 32;
  localparam int SCR_W    = 640;
  localparam int SCR_H    = 480;
  localparam int X0       = 320;
  localparam int Y0       = 0;
  localparam int H_TOTAL  = 2;
  localparam int V_TOTAL  = 482;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  localparam int B_R = 0;
  localparam int B_L = 1;
  localparam int B_D = 2;
  localparam int B_U = 3;
  localparam int B_C = 4;

  localparam int M_C = 1;
  localparam int M_U = 2;
  localparam int M_D = 3;
  localparam int M_L = 4;
  localparam int M_R = 5;

  typedef struct {
    int x;
    int y;
  } pos_t;

  logic        clk_25MHz = 1'b0;
  logic        reset_n   = 1'b0;
  logic [4:0]  btns      = 5'b0;
  logic [10:0] hcount    = 11'd0;
  logic [10:0] vcount    = 11'd0;
  logic [10:0] block_x;
  logic [10:0] block_y;
  logic        move_pulse;
  logic        busy;

  int   checks  = 0;
  int   errors  = 0;
  int   model_x = X0;
  int   model_y = Y0;
  pos_t exp_q[$];

  block_motion_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(64)
  ) dut (
    .clk_25MHz (clk_25MHz),
    .reset_n   (reset_n),
    .btnC      (btns[B_C]),
    .btnU      (btns[B_U]),
    .btnD      (btns[B_D]),
    .btnL      (btns[B_L]),
    .btnR      (btns[B_R]),
    .hcount    (hcount),
    .vcount    (vcount),
    .block_x   (block_x),
    .block_y   (block_y),
    .move_pulse(move_pulse),
    .busy      (busy)
  );

  // 25 MHz pixel clock.
  always #20 clk_25MHz = ~clk_25MHz;

  // Shortened VGA raster: tiny lines, full vertical range so the blanking line exists.
  always @(posedge clk_25MHz) begin
    if (hcount == 11'(H_TOTAL - 1)) begin
      hcount <= 11'd0;
      vcount <= (vcount == 11'(V_TOTAL - 1)) ? 11'd0 : vcount + 11'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  task automatic push_move(input int d);
    pos_t p;
    case (d)
      M_C: begin model_x = X0; model_y = Y0; end
      M_U: model_y = (model_y < STEP) ? SCR_H - STEP : model_y - STEP;
      M_D: model_y = (model_y + STEP >= SCR_H) ? 0 : model_y + STEP;
      M_L: model_x = (model_x < STEP) ? SCR_W - STEP : model_x - STEP;
      M_R: model_x = (model_x + STEP >= SCR_W) ? 0 : model_x + STEP;
      default: ;
    endcase
    p.x = model_x;
    p.y = model_y;
    exp_q.push_back(p);
  endtask

  task automatic wait_move(input string name);
    int   n = 0;
    pos_t e;
    do begin
      @(negedge clk_25MHz);
      n++;
    end while (move_pulse !== 1'b1 && n < 2 * FRAME);
    checks++;
    if (move_pulse !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s timeout: move_pulse=%b required 1", name, move_pulse);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s unexpected commit: queue empty, block=%0d/%0d", name, block_x, block_y);
    end else begin
      e = exp_q.pop_front();
      if (block_x !== 11'(e.x) || block_y !== 11'(e.y)) begin
        errors++;
        $display("[TB] FAIL %s position: got %0d/%0d required %0d/%0d",
                 name, block_x, block_y, e.x, e.y);
      end
    end
    checks++;
    if (move_pulse === 1'b1 && (hcount !== 11'd1 || vcount !== 11'(SCR_H))) begin
      errors++;
      $display("[TB] FAIL %s commit timing: h=%0d v=%0d required h=1 v=%0d",
               name, hcount, vcount, SCR_H);
    end
    @(negedge clk_25MHz);
    checks++;
    if (move_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s pulse width: move_pulse=%b required 0", name, move_pulse);
    end
  endtask

  task automatic expect_quiet(input int cycles, input bit check_idle, input string name);
    int pulses = 0;
    int moved  = 0;
    int busy_n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_25MHz);
      if (move_pulse === 1'b1) pulses++;
      if (busy === 1'b1) busy_n++;
      if (block_x !== 11'(model_x) || block_y !== 11'(model_y)) moved++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL %s pulses: got %0d required 0", name, pulses);
    end
    checks++;
    if (moved != 0) begin
      errors++;
      $display("[TB] FAIL %s position: got %0d/%0d required %0d/%0d",
               name, block_x, block_y, model_x, model_y);
    end
    if (check_idle) begin
      checks++;
      if (busy_n != 0) begin
        errors++;
        $display("[TB] FAIL %s busy cycles: got %0d required 0", name, busy_n);
      end
    end
  endtask

  task automatic wait_busy(input logic val, input string name);
    int n = 0;
    while (busy !== val && n < 40) begin
      @(negedge clk_25MHz);
      n++;
    end
    checks++;
    if (busy !== val) begin
      errors++;
      $display("[TB] FAIL %s busy: got %b required %b", name, busy, val);
    end
  endtask

  task automatic wait_line(input int line);
    int n = 0;
    while (vcount != 11'(line) && n < 2 * FRAME) begin
      @(negedge clk_25MHz);
      n++;
    end
  endtask

  task automatic press_moves(input int b, input int d, input int n, input string name);
    for (int i = 0; i < n; i++) push_move(d);
    btns[b] = 1'b1;
    for (int i = 0; i < n; i++) wait_move(name);
    btns[b] = 1'b0;
    repeat (20) @(negedge clk_25MHz);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s release busy: got %b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_25MHz);
    checks++;
    if (block_x !== 11'(X0) || block_y !== 11'(Y0) || move_pulse !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset values: got x=%0d y=%0d pulse=%b busy=%b required %0d/%0d/0/0",
               block_x, block_y, move_pulse, busy, X0, Y0);
    end
    reset_n = 1'b1;
    expect_quiet(3 * FRAME, 1'b1, "reset_idle");
  endtask

  task automatic test_glitch();
    btns[B_D] = 1'b1;
    repeat (2) @(negedge clk_25MHz);
    btns[B_D] = 1'b0;
    expect_quiet(FRAME + FRAME / 2, 1'b1, "glitch");
  endtask

  task automatic test_hold_down();
    push_move(M_D);
    push_move(M_D);
    btns[B_D] = 1'b1;
    wait_move("hold_down_1");
    wait_move("hold_down_2");
    btns[B_D] = 1'b0;
    repeat (20) @(negedge clk_25MHz);
    expect_quiet(FRAME + 10, 1'b1, "hold_down_release");
  endtask

  task automatic test_wrap();
    press_moves(B_U, M_U, 3, "wrap_up");
    press_moves(B_D, M_D, 1, "wrap_down");
    press_moves(B_R, M_R, 10, "wrap_right");
  endtask

  task automatic test_priority();
    push_move(M_U);
    btns[B_U] = 1'b1;
    btns[B_L] = 1'b1;
    wait_move("prio_up");
    btns[B_U] = 1'b0;
    push_move(M_L);
    wait_move("prio_left");
    btns[B_L] = 1'b0;
    repeat (20) @(negedge clk_25MHz);
    expect_quiet(FRAME + 10, 1'b1, "prio_release");
  endtask

  task automatic test_abort();
    wait_line(10);
    btns[B_R] = 1'b1;
    wait_busy(1'b1, "abort_pend");
    btns[B_R] = 1'b0;
    wait_busy(1'b0, "abort_drop");
    expect_quiet(FRAME + 10, 1'b1, "abort_quiet");
  endtask

  task automatic test_reset_pend();
    wait_line(10);
    btns[B_D] = 1'b1;
    wait_busy(1'b1, "rst_pend_busy");
    @(negedge clk_25MHz);
    reset_n = 1'b0;
    #1;
    checks++;
    if (block_x !== 11'(X0) || block_y !== 11'(Y0) || busy !== 1'b0 || move_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_pend async: got x=%0d y=%0d busy=%b pulse=%b required %0d/%0d/0/0",
               block_x, block_y, busy, move_pulse, X0, Y0);
    end
    btns[B_D] = 1'b0;
    model_x = X0;
    model_y = Y0;
    repeat (3) @(negedge clk_25MHz);
    reset_n = 1'b1;
    expect_quiet(FRAME + 10, 1'b1, "rst_pend_quiet");
  endtask

  task automatic test_recenter();
    press_moves(B_R, M_R, 1, "recenter_r");
    press_moves(B_D, M_D, 1, "recenter_d");
    press_moves(B_C, M_C, 1, "recenter_c");
  endtask

  // Run each scenario in turn, then report.
  initial begin
    $display("[TB] starting block_motion_ctrl bench");
    test_reset();
    test_glitch();
    test_hold_down();
    test_wrap();
    test_priority();
    test_abort();
    test_reset_pend();
    test_recenter();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: %0d left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
